// File: rtl/jh512_msg_padder.sv
// Packs 64-bit message words into 512-bit JH512 blocks with byte-granular padding.
// Define JH512_LEN128_EN for a full 128-bit bit-length counter (default: 64-bit, wrapping).
module jh512_msg_padder (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [63:0]  in_data,
    input  logic [3:0]   in_nbytes,
    input  logic         in_last,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [511:0] blk_data,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         blk_first,
    output logic         blk_last
);

`ifdef JH512_LEN128_EN
    localparam int LEN_W = 128;
`else
    localparam int LEN_W = 64;
`endif

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        SEND     = 2'd1,
        SEND_PAD = 2'd2
    } state_t;

    state_t             r_state;
    logic [2:0]         r_idx;
    logic [LEN_W-1:0]   r_len;
    logic [511:0]       r_buf;
    logic               r_first_flag;
    logic               r_msg_end;
    logic               r_boundary;
    logic               r_in_ready;
    logic               r_blk_valid;
    logic               r_blk_first;
    logic               r_blk_last;

    logic [3:0]         w_n;
    logic [63:0]        w_word;
    logic [LEN_W-1:0]   w_len_sum;
    logic [127:0]       w_len_field;
    logic [8:0]         w_base;
    logic [8:0]         w_mark_base;
    logic               w_empty_last;

    // Partial counts only make sense on the final word; anything else is a full word.
    assign w_n          = (!in_last || (in_nbytes > 4'd8)) ? 4'd8 : in_nbytes;
    assign w_len_sum    = r_len + LEN_W'({w_n, 3'b000});
    assign w_base       = {3'd7 - r_idx, 6'd0};
    assign w_mark_base  = {3'd6 - r_idx, 6'd56};
    assign w_empty_last = in_last && (w_n == 4'd0) && (r_idx == 3'd0);

`ifdef JH512_LEN128_EN
    assign w_len_field = r_len;
`else
    assign w_len_field = {64'd0, r_len};
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi = gi + 1) begin : g_lane
            assign w_word[63-8*gi -: 8] = (4'(gi) < w_n) ? in_data[63-8*gi -: 8] :
                                          ((4'(gi) == w_n) && in_last) ? 8'h80 : 8'h00;
        end
    endgenerate

    function automatic logic [511:0] pad_block(input logic marker, input logic [127:0] len);
        pad_block = {(marker ? 8'h80 : 8'h00), 376'd0, len};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= FILL;
            r_idx        <= '0;
            r_len        <= '0;
            r_buf        <= '0;
            r_first_flag <= 1'b1;
            r_msg_end    <= 1'b0;
            r_boundary   <= 1'b0;
            r_in_ready   <= 1'b1;
            r_blk_valid  <= 1'b0;
            r_blk_first  <= 1'b0;
            r_blk_last   <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (r_in_ready && in_valid) begin
                        r_len <= w_len_sum;
                        if (w_empty_last) begin
                            // Message ended on a block boundary with nothing new: only the pad block remains.
                            r_state      <= SEND_PAD;
                            r_buf        <= pad_block(1'b1, w_len_field);
                            r_in_ready   <= 1'b0;
                            r_blk_valid  <= 1'b1;
                            r_blk_first  <= r_first_flag;
                            r_blk_last   <= 1'b1;
                            r_first_flag <= 1'b0;
                        end else begin
                            r_buf[w_base +: 64] <= w_word;
                            if (in_last && (w_n == 4'd8) && (r_idx != 3'd7)) begin
                                r_buf[w_mark_base +: 8] <= 8'h80;
                            end
                            if (in_last || (r_idx == 3'd7)) begin
                                r_state     <= SEND;
                                r_in_ready  <= 1'b0;
                                r_blk_valid <= 1'b1;
                                r_blk_first <= r_first_flag;
                                r_blk_last  <= 1'b0;
                                r_msg_end   <= in_last;
                                r_boundary  <= in_last && (w_n == 4'd8) && (r_idx == 3'd7);
                            end else begin
                                r_idx <= r_idx + 3'd1;
                            end
                        end
                    end
                end
                SEND: begin
                    if (blk_ready) begin
                        r_first_flag <= 1'b0;
                        r_blk_first  <= 1'b0;
                        r_idx        <= '0;
                        if (r_msg_end) begin
                            r_state    <= SEND_PAD;
                            r_buf      <= pad_block(r_boundary, w_len_field);
                            r_blk_last <= 1'b1;
                        end else begin
                            r_state     <= FILL;
                            r_buf       <= '0;
                            r_blk_valid <= 1'b0;
                            r_in_ready  <= 1'b1;
                        end
                    end
                end
                SEND_PAD: begin
                    if (blk_ready) begin
                        r_state      <= FILL;
                        r_buf        <= '0;
                        r_idx        <= '0;
                        r_len        <= '0;
                        r_first_flag <= 1'b1;
                        r_msg_end    <= 1'b0;
                        r_boundary   <= 1'b0;
                        r_in_ready   <= 1'b1;
                        r_blk_valid  <= 1'b0;
                        r_blk_first  <= 1'b0;
                        r_blk_last   <= 1'b0;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign blk_data  = r_buf;
    assign blk_valid = r_blk_valid;
    assign blk_first = r_blk_first;
    assign blk_last  = r_blk_last;

endmodule

// File: tb/tb_jh512_msg_padder.sv
// Bench for jh512_msg_padder: byte-stream padding model plus directed literal cases,
// a back-pressure stall, a mid-message reset and randomized messages.
module tb_jh512_msg_padder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [63:0]  in_data = '0;
    logic [3:0]   in_nbytes = '0;
    logic         in_last = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_ready = 1'b1;
    logic         blk_first;
    logic         blk_last;

    jh512_msg_padder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_nbytes (in_nbytes),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .blk_data  (blk_data),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_first (blk_first),
        .blk_last  (blk_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [511:0] data;
        logic         first;
        logic         last;
    } blk_t;

    blk_t        exp_q[$];
    blk_t        got_q[$];
    logic [7:0]  cur[$];
    int          checks = 0;
    int          failures = 0;
    logic        force_low = 1'b0;
    logic        rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Model: message ++ 0x80 ++ zeros to a block multiple, plus a whole extra block when the
    // marker landed inside a block; the final 16 bytes always carry the bit length.
    task automatic model_push(input logic [7:0] msg[$]);
        int           len_b = msg.size();
        int           total;
        logic [7:0]   s[$];
        logic [127:0] bitlen;
        blk_t         b;
        total  = ((len_b % 64) == 0) ? len_b + 64 : (len_b / 64 + 2) * 64;
        bitlen = 128'(len_b) * 128'd8;
        for (int i = 0; i < total; i++)
            s.push_back((i < len_b) ? msg[i] : ((i == len_b) ? 8'h80 : 8'h00));
        for (int i = 0; i < 16; i++)
            s[total-16+i] = bitlen[127-8*i -: 8];
        for (int k = 0; k < total / 64; k++) begin
            b.data = '0;
            for (int j = 0; j < 64; j++)
                b.data[511-8*j -: 8] = s[64*k+j];
            b.first = (k == 0);
            b.last  = (k == total / 64 - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic gen(input int len_b, input bit seq);
        cur.delete();
        for (int i = 0; i < len_b; i++)
            cur.push_back(seq ? 8'(i) : 8'($urandom_range(255)));
    endtask

    task automatic send_word(input logic [63:0] d, input logic [3:0] nb, input logic last);
        bit acc = 1'b0;
        int budget = 0;
        in_data   = d;
        in_nbytes = nb;
        in_last   = last;
        in_valid  = 1'b1;
        while (!acc) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            budget++;
            if (!acc && budget > 500) begin
                chk("in_ready_timeout", 512'(acc), 512'd1);
                break;
            end
        end
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom};
        if ($urandom_range(3) == 0)
            repeat ($urandom_range(3, 1)) begin @(posedge clk); #1; end
    endtask

    task automatic send_msg(input logic [7:0] msg[$]);
        int          len_b = msg.size();
        int          nw = (len_b + 7) / 8;
        int          nb;
        bit          extra;
        bit          lastw;
        logic [63:0] w;
        model_push(msg);
        extra = ((len_b % 8) == 0) && ((len_b == 0) || ($urandom_range(1) == 1));
        for (int k = 0; k < nw; k++) begin
            lastw = (k == nw - 1) && !extra;
            nb = len_b - 8 * k;
            if (nb > 8) nb = 8;
            w = {$urandom, $urandom};
            for (int j = 0; j < nb; j++)
                w[63-8*j -: 8] = msg[8*k+j];
            if (!lastw)
                send_word(w, 4'($urandom_range(15)), 1'b0);
            else
                send_word(w, ((nb == 8) && ($urandom_range(1) == 1)) ? 4'($urandom_range(15, 9)) : 4'(nb), 1'b1);
        end
        if (extra)
            send_word({$urandom, $urandom}, 4'd0, 1'b1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending_blocks", 512'(exp_q.size()), 512'd0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    always @(posedge clk) begin
        #1;
        blk_ready = force_low ? 1'b0 : (rand_rdy ? ($urandom_range(3) != 0) : 1'b1);
    end

    logic         prev_v = 1'b0;
    logic         prev_r = 1'b0;
    logic         prev_f = 1'b0;
    logic         prev_l = 1'b0;
    logic [511:0] prev_d = '0;
    blk_t         e;
    blk_t         g;

    always @(negedge clk) begin
        if (rst_n) begin
            if (blk_valid)
                chk("in_ready_while_pending", 512'(in_ready), 512'd0);
            if (prev_v && !prev_r) begin
                chk("stall_data_stable", blk_data, prev_d);
                chk("stall_flags_stable", 512'({blk_valid, blk_first, blk_last}), 512'({1'b1, prev_f, prev_l}));
            end
            if (blk_valid && blk_ready) begin
                g.data  = blk_data;
                g.first = blk_first;
                g.last  = blk_last;
                got_q.push_back(g);
                if (exp_q.size() == 0) begin
                    chk("unexpected_block", 512'(blk_valid), 512'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("blk_data", blk_data, e.data);
                    chk("blk_first_last", 512'({blk_first, blk_last}), 512'({e.first, e.last}));
                end
            end
            prev_v = blk_valid;
            prev_r = blk_ready;
            prev_d = blk_data;
            prev_f = blk_first;
            prev_l = blk_last;
        end else begin
            prev_v = 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    logic [511:0] lit;
    int           n;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 512'(in_ready), 512'd1);
        chk("reset_blk_valid", 512'(blk_valid), 512'd0);
        chk("reset_blk_flags", 512'({blk_first, blk_last}), 512'd0);
        chk("reset_blk_data", blk_data, 512'd0);
        @(posedge clk);
        #1;

        // Empty message
        got_q.delete();
        gen(0, 1'b1);
        send_msg(cur);
        drain();
        chk("empty_nblocks", 512'(got_q.size()), 512'd1);
        if (got_q.size() >= 1) begin
            chk("empty_data", got_q[0].data, {8'h80, 504'd0});
            chk("empty_flags", 512'({got_q[0].first, got_q[0].last}), 512'(2'b11));
        end

        // "abc"
        got_q.delete();
        cur.delete();
        cur.push_back(8'h61); cur.push_back(8'h62); cur.push_back(8'h63);
        send_msg(cur);
        drain();
        chk("abc_nblocks", 512'(got_q.size()), 512'd2);
        if (got_q.size() >= 2) begin
            chk("abc_blk1", got_q[0].data, {8'h61, 8'h62, 8'h63, 8'h80, 480'd0});
            chk("abc_blk1_flags", 512'({got_q[0].first, got_q[0].last}), 512'(2'b10));
            chk("abc_blk2", got_q[1].data, {384'd0, 128'h18});
            chk("abc_blk2_flags", 512'({got_q[1].first, got_q[1].last}), 512'(2'b01));
        end

        // 64-byte message
        got_q.delete();
        gen(64, 1'b1);
        send_msg(cur);
        drain();
        chk("m64_nblocks", 512'(got_q.size()), 512'd2);
        if (got_q.size() >= 2) begin
            for (int i = 0; i < 64; i++) lit[511-8*i -: 8] = 8'(i);
            chk("m64_blk1", got_q[0].data, lit);
            chk("m64_blk2", got_q[1].data, {8'h80, 376'd0, 128'h200});
            chk("m64_blk2_flags", 512'({got_q[1].first, got_q[1].last}), 512'(2'b01));
        end

        // 65-byte message
        got_q.delete();
        gen(65, 1'b1);
        send_msg(cur);
        drain();
        chk("m65_nblocks", 512'(got_q.size()), 512'd3);
        if (got_q.size() >= 3) begin
            chk("m65_blk2_marker", 512'(got_q[1].data[503:496]), 512'h80);
            chk("m65_blk3_len", 512'(got_q[2].data[127:0]), 512'h208);
            chk("m65_first_flags", 512'({got_q[0].first, got_q[1].first, got_q[2].first}), 512'(3'b100));
        end

        // Back-pressure: hold blk_ready low for 5 cycles while more words wait upstream
        force_low = 1'b1;
        gen(100, 1'b0);
        fork
            send_msg(cur);
        join_none
        n = 0;
        while (!blk_valid && n < 200) begin @(posedge clk); #1; n++; end
        chk("stall_blk_valid_seen", 512'(blk_valid), 512'd1);
        repeat (5) begin @(posedge clk); #1; end
        chk("stall_in_ready_low", 512'(in_ready), 512'd0);
        force_low = 1'b0;
        wait fork;
        drain();

        // Reset after 3 words of a message
        for (int k = 0; k < 3; k++) send_word({$urandom, $urandom}, 4'd8, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_blk_valid", 512'(blk_valid), 512'd0);
        chk("midreset_in_ready", 512'(in_ready), 512'd1);
        @(posedge clk);
        #1;
        got_q.delete();
        gen(20, 1'b0);
        send_msg(cur);
        drain();
        chk("postreset_nblocks", 512'(got_q.size()), 512'd2);
        if (got_q.size() >= 2) begin
            chk("postreset_first", 512'(got_q[0].first), 512'd1);
            chk("postreset_len", 512'(got_q[1].data[127:0]), 512'd160);
        end

        // Randomized messages with random back-pressure
        rand_rdy = 1'b1;
        for (int m = 0; m < 30; m++) begin
            gen($urandom_range(200, 0), 1'b0);
            send_msg(cur);
            if ($urandom_range(3) == 0) drain();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jh512_msg_padder.md
JH512_MSG_PADDER -- requirements
Module: jh512_msg_padder

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port in_data, input, 64 bits: message word; byte 0 is in [63:56].
REQ-004 SHALL have port in_nbytes, input, 4 bits: valid bytes in the word, 0..8; values below 8 are meaningful only with in_last.
REQ-005 SHALL have port in_last, input, 1 bit: this word ends the message.
REQ-006 SHALL have port in_valid, input, 1 bit; in_ready, output, 1 bit: input handshake.
REQ-007 SHALL have port blk_data, output, 512 bits: padded block for the JH512 core; byte 0 is in [511:504].
REQ-008 SHALL have port blk_valid, output, 1 bit; blk_ready, input, 1 bit: block handshake.
REQ-009 SHALL have port blk_first, output, 1 bit: first block of a message (core loads IV); blk_last, output, 1 bit: final block (core emits hash).

Function
REQ-010 SHALL transfer an input word when in_valid && in_ready, and a block when blk_valid && blk_ready.
REQ-011 SHALL apply JH padding at byte granularity: message bytes, then 0x80, then zero bytes, then the bit length as a 128-bit big-endian field in bytes 48..63 of the final block.
REQ-012 SHALL implement FSM FILL -> SEND -> (FILL | SEND_PAD) -> FILL; reset state is FILL.
REQ-013 FILL: in_ready=1; accepted words pack at word index 0..7 (index 0 = [511:448]); the index increments per accepted word.
REQ-014 FILL -> SEND on acceptance of word index 7 with 8 bytes, or on acceptance of any in_last word.
REQ-015 On an in_last word with n<8 bytes, the buffer SHALL hold 0x80 at byte n of that word, with zeros in all following bytes of the block.
REQ-016 SEND: blk_valid=1, in_ready=0; blk_data, blk_first and blk_last SHALL stay stable until accepted.
REQ-017 On SEND acceptance: if the message is not finished, go to FILL with a cleared buffer; if it ended inside this block (0x80 already placed), go to SEND_PAD; if it ended exactly on the block boundary, go to SEND_PAD with 0x80 in byte 0.
REQ-018 SEND_PAD: emit the block {0x80 if boundary case else 0x00, zeros, length}, with blk_last=1; on acceptance go to FILL, clear the counters and set the first-block flag.
REQ-019 blk_first SHALL be 1 on the first block emitted after reset or after a completed message, and 0 otherwise.
REQ-020 SHALL keep a running message bit length, adding 8*n per accepted word (n = min(in_nbytes, 8)).
REQ-021 An in_last word with in_nbytes=0 SHALL add no bytes; the 0x80 goes at the current byte position, or in the SEND_PAD block if the position is a block boundary.
REQ-022 in_nbytes>8, or <8 without in_last, SHALL be treated as 8.
REQ-023 Latency: blk_valid SHALL assert in the cycle after the word that completes the block is accepted; SEND_PAD blk_valid SHALL assert in the cycle after SEND acceptance.
REQ-024 Sustained throughput: 8 word cycles plus at least 1 block cycle per 512-bit block; no input is accepted while a block is pending.

Reset
REQ-025 When rst_n=0 at a clock edge, all of the following SHALL take effect regardless of state, including mid-message and mid-handshake:
- state goes to FILL;
- word index, bit length and buffer are cleared;
- the first-block flag is set;
- outputs become in_ready=1 (from the first cycle after reset), blk_valid=0, blk_first=0, blk_last=0 and blk_data=0.

Configuration
REQ-026 With JH512_LEN128_EN defined, the bit-length counter SHALL be 128 bits and fill the whole length field.
REQ-027 Without JH512_LEN128_EN, the counter SHALL be 64 bits, wrap modulo 2^64, and the upper 64 bits of the length field SHALL be zero.

Verification
REQ-028 Empty message (one in_last word, nbytes=0): exactly one block is emitted, with byte0=0x80, all other bytes zero, length 0, blk_first=1 and blk_last=1.
REQ-029 "abc" (in_data=0x6162630000000000, nbytes=3, last): 
- block 1 = 61 62 63 80 00..00, first=1, last=0;
- block 2 = zeros with length 0x18, first=0, last=1.
REQ-030 A 64-byte message (8 full words, last on the 8th): block 1 = message bytes; block 2 = byte0 0x80 with length 0x200, last=1.
REQ-031 Hold blk_ready low for 5 cycles in SEND: blk_data, blk_first and blk_last stay stable, in_ready=0, and no input words are lost.
REQ-032 Assert rst_n=0 after 3 words of a message: the next cycle shows blk_valid=0 and in_ready=1; the next message's first block has blk_first=1 and a correct length.
REQ-033 A 65-byte message: 3 blocks are emitted, 0x80 is at byte 1 of block 2, block 3 carries length 0x208, and blk_first is set only on block 1.
